// File: rtl/mem_pkg.sv
// Shared types and constants for the memory_hs RAM and its read pipeline.
package mem_pkg;

    typedef enum logic {
        WRITE_FIRST = 1'b0,
        READ_FIRST  = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } mem_state_e;

    localparam int MAX_RD_LAT = 4;

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-response delay line: RD_LAT stages of {valid, err, data}.
// Data and err stages only load on a valid beat, so the output holds between responses.
module mem_rd_pipe #(
    parameter int RD_LAT = 2,
    parameter int DW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_err,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic          out_err,
    output logic [DW-1:0] out_data
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] vld_d;
    logic [RD_LAT-1:0] err_q;
    logic [RD_LAT-1:0] err_d;
    logic [DW-1:0]     data_q [RD_LAT];
    logic [DW-1:0]     data_d [RD_LAT];

    // Next-stage values: shift valids, load err/data only behind a valid beat.
    always_comb begin
        vld_d[0]  = in_valid;
        err_d[0]  = in_valid ? in_err : err_q[0];
        data_d[0] = in_valid ? in_data : data_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            err_d[i]  = vld_q[i-1] ? err_q[i-1] : err_q[i];
            data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
        end
    end

    // Stage registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= {RD_LAT{1'b0}};
            err_q <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                data_q[i] <= {DW{1'b0}};
            end
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            for (int i = 0; i < RD_LAT; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_err   = err_q[RD_LAT-1];
    assign out_data  = data_q[RD_LAT-1];

endmodule

// File: rtl/memory_hs.sv
// 1R/1W synchronous RAM with valid/ready handshakes, byte enables, write ack,
// out-of-range error reporting, post-reset clear sweep and configurable read latency.
module memory_hs
    import mem_pkg::*;
#(
    parameter int            ADDR_W         = 9,
    parameter int            DEPTH          = 512,
    parameter int            DW             = 16,
    parameter int            RD_LAT         = 2,
    parameter rdw_mode_e     RDW_MODE       = WRITE_FIRST,
    parameter bit            CLEAR_ON_RESET = 1'b1,
    parameter logic [DW-1:0] INIT_VAL       = {DW{1'b0}},
    localparam int           BE_W           = DW / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic [BE_W-1:0]   wr_be,
    output logic              wr_ack,
    output logic              wr_err,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_rvalid,
    output logic [DW-1:0]     rd_rdata,
    output logic              rd_err,
    output logic              init_done
);

    if (DEPTH > (1 << ADDR_W)) begin : g_chk_depth
        $error("memory_hs: DEPTH does not fit in ADDR_W address bits");
    end
    if ((DW % 8) != 0) begin : g_chk_dw
        $error("memory_hs: DW must be a multiple of 8");
    end
    if ((RD_LAT < 1) || (RD_LAT > MAX_RD_LAT)) begin : g_chk_lat
        $error("memory_hs: RD_LAT out of range 1..MAX_RD_LAT");
    end

    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam mem_state_e        RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

    function automatic logic [DW-1:0] be_merge(
        input logic [DW-1:0]   old_word,
        input logic [DW-1:0]   new_word,
        input logic [BE_W-1:0] be
    );
        logic [DW-1:0] res;
        res = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [DW-1:0] mem_array [DEPTH];

    mem_state_e        state_q;
    mem_state_e        state_d;
    logic [ADDR_W-1:0] init_cnt_q;
    logic [ADDR_W-1:0] init_cnt_d;
    logic              run_q;
    logic              run_d;
    logic              wr_ack_q;
    logic              wr_ack_d;
    logic              wr_err_q;
    logic              wr_err_d;

    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              wr_inr_s;
    logic              rd_inr_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DW-1:0]     mem_wdata_s;
    logic [BE_W-1:0]   mem_wbe_s;
    logic [DW-1:0]     rd_word_s;

    assign wr_acc_s = wr_valid & run_q;
    assign rd_acc_s = rd_valid & run_q;
    assign wr_inr_s = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_inr_s = ({1'b0, rd_addr} < DEPTH_L);

    // FSM state and sweep counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_STATE;
            init_cnt_q <= {ADDR_W{1'b0}};
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Next state: sweep one word per cycle, then stay in RUN until reset.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == LAST_ADDR) begin
                    state_d    = ST_RUN;
                    init_cnt_d = {ADDR_W{1'b0}};
                end else begin
                    state_d    = ST_INIT;
                    init_cnt_d = init_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d    = RST_STATE;
                init_cnt_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    // FSM outputs: RAM write port mux (sweep vs. client), ready and ack.
    always_comb begin
        run_d    = (state_d == ST_RUN);
        wr_ack_d = wr_acc_s;
        wr_err_d = wr_acc_s & ~wr_inr_s;
        case (state_q)
            ST_INIT: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = init_cnt_q;
                mem_wdata_s = INIT_VAL;
                mem_wbe_s   = {BE_W{1'b1}};
            end
            ST_RUN: begin
                mem_we_s    = wr_acc_s & wr_inr_s;
                mem_waddr_s = wr_addr;
                mem_wdata_s = wr_data;
                mem_wbe_s   = wr_be;
            end
            default: begin
                mem_we_s    = 1'b0;
                mem_waddr_s = {ADDR_W{1'b0}};
                mem_wdata_s = {DW{1'b0}};
                mem_wbe_s   = {BE_W{1'b0}};
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            run_q    <= run_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Storage array with per-byte write enables; contents are never reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < BE_W; i++) begin
                if (mem_wbe_s[i]) begin
                    mem_array[mem_waddr_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Read word for the pipeline; WRITE_FIRST forwards same-cycle write bytes.
    always_comb begin
        rd_word_s = {DW{1'b0}};
        if (rd_inr_s) begin
            rd_word_s = mem_array[rd_addr];
            if ((RDW_MODE == WRITE_FIRST) && wr_acc_s && wr_inr_s && (wr_addr == rd_addr)) begin
                rd_word_s = be_merge(mem_array[rd_addr], wr_data, wr_be);
            end else begin
                rd_word_s = mem_array[rd_addr];
            end
        end else begin
            rd_word_s = {DW{1'b0}};
        end
    end

    mem_rd_pipe #(
        .RD_LAT (RD_LAT),
        .DW     (DW)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_acc_s),
        .in_err    (~rd_inr_s),
        .in_data   (rd_word_s),
        .out_valid (rd_rvalid),
        .out_err   (rd_err),
        .out_data  (rd_rdata)
    );

    assign wr_ready  = run_q;
    assign rd_ready  = run_q;
    assign init_done = run_q;
    assign wr_ack    = wr_ack_q;
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_memory_hs.sv
// Directed bench: two memory_hs instances share stimulus. A uses the defaults
// (WRITE_FIRST, RD_LAT=2, DEPTH=512); B uses READ_FIRST, RD_LAT=1, DEPTH=300, INIT_VAL=0x00A5.
module tb_memory_hs;
    import mem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic [8:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_valid;
    logic [8:0]  rd_addr;

    logic        a_wr_ready, a_wr_ack, a_wr_err, a_rd_ready, a_rd_rvalid, a_rd_err, a_init_done;
    logic [15:0] a_rd_rdata;
    logic        b_wr_ready, b_wr_ack, b_wr_err, b_rd_ready, b_rd_rvalid, b_rd_err, b_init_done;
    logic [15:0] b_rd_rdata;

    int n_checks;
    int n_pass;

    memory_hs u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(a_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .wr_ack(a_wr_ack), .wr_err(a_wr_err),
        .rd_valid(rd_valid), .rd_ready(a_rd_ready), .rd_addr(rd_addr),
        .rd_rvalid(a_rd_rvalid), .rd_rdata(a_rd_rdata), .rd_err(a_rd_err),
        .init_done(a_init_done)
    );

    memory_hs #(
        .DEPTH(300), .RD_LAT(1), .RDW_MODE(READ_FIRST), .INIT_VAL(16'h00A5)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(b_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .wr_ack(b_wr_ack), .wr_err(b_wr_err),
        .rd_valid(rd_valid), .rd_ready(b_rd_ready), .rd_addr(rd_addr),
        .rd_rvalid(b_rd_rvalid), .rd_rdata(b_rd_rdata), .rd_err(b_rd_err),
        .init_done(b_init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk_eq({tag, ".a_out"}, {a_wr_ready, a_wr_ack, a_wr_err, a_rd_ready, a_rd_rvalid,
                                 a_rd_err, a_init_done, a_rd_rdata}, 32'h0);
        chk_eq({tag, ".b_out"}, {b_wr_ready, b_wr_ack, b_wr_err, b_rd_ready, b_rd_rvalid,
                                 b_rd_err, b_init_done, b_rd_rdata}, 32'h0);
    endtask

    // Counts edges from reset release until init_done; rvalid must stay low throughout.
    task automatic sweep(input string tag);
        int a_cnt;
        int b_cnt;
        logic saw_rv;
        a_cnt  = 0;
        b_cnt  = 0;
        saw_rv = 1'b0;
        for (int i = 1; i <= 2000; i++) begin
            tick();
            saw_rv = saw_rv | a_rd_rvalid | b_rd_rvalid;
            if (b_init_done && (b_cnt == 0)) b_cnt = i;
            if (a_init_done) begin
                a_cnt = i;
                break;
            end
        end
        chk_eq({tag, ".a_len"}, a_cnt, 32'd512);
        chk_eq({tag, ".b_len"}, b_cnt, 32'd300);
        chk_eq({tag, ".ready"}, {a_wr_ready, a_rd_ready, b_wr_ready, b_rd_ready}, 32'hF);
        chk_eq({tag, ".no_rv"}, {31'd0, saw_rv}, 32'h0);
    endtask

    task automatic wr(input string tag, input logic [8:0] a, input logic [15:0] d,
                      input logic [1:0] be, input logic exp_a_err, input logic exp_b_err);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = be;
        tick();
        wr_valid = 1'b0;
        chk_eq({tag, ".ack"}, {a_wr_ack, b_wr_ack}, 32'h3);
        chk_eq({tag, ".err"}, {a_wr_err, b_wr_err}, {30'd0, exp_a_err, exp_b_err});
        tick();
        chk_eq({tag, ".ack_off"}, {a_wr_ack, b_wr_ack}, 32'h0);
    endtask

    task automatic rd_chk(input string tag, input logic [8:0] a,
                          input logic [15:0] exp_a, input logic exp_a_err,
                          input logic [15:0] exp_b, input logic exp_b_err);
        rd_valid = 1'b1;
        rd_addr  = a;
        tick();
        rd_valid = 1'b0;
        chk_eq({tag, ".b_rv"}, b_rd_rvalid, 32'h1);
        chk_eq({tag, ".b_data"}, {b_rd_err, b_rd_rdata}, {15'd0, exp_b_err, exp_b});
        chk_eq({tag, ".a_early"}, a_rd_rvalid, 32'h0);
        tick();
        chk_eq({tag, ".a_rv"}, a_rd_rvalid, 32'h1);
        chk_eq({tag, ".a_data"}, {a_rd_err, a_rd_rdata}, {15'd0, exp_a_err, exp_a});
        chk_eq({tag, ".b_off"}, b_rd_rvalid, 32'h0);
        tick();
        chk_eq({tag, ".a_off"}, a_rd_rvalid, 32'h0);
        chk_eq({tag, ".a_hold"}, a_rd_rdata, {16'd0, exp_a});
    endtask

    // Same-cycle write and read of 0x020.
    task automatic rdw(input string tag, input logic [15:0] d, input logic [1:0] be,
                       input logic [15:0] exp_a, input logic [15:0] exp_b);
        wr_valid = 1'b1;
        wr_addr  = 9'h020;
        wr_data  = d;
        wr_be    = be;
        rd_valid = 1'b1;
        rd_addr  = 9'h020;
        tick();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        chk_eq({tag, ".ack"}, {a_wr_ack, b_wr_ack}, 32'h3);
        chk_eq({tag, ".b"}, {b_rd_rvalid, b_rd_rdata}, {15'd0, 1'b1, exp_b});
        tick();
        chk_eq({tag, ".a"}, {a_rd_rvalid, a_rd_rdata}, {15'd0, 1'b1, exp_a});
        tick();
    endtask

    logic [15:0] b2b_a_data [5];
    logic [15:0] b2b_b_data [5];
    logic [4:0]  b2b_a_rv;
    logic [4:0]  b2b_b_rv;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = 9'h000;
        wr_data  = 16'h0000;
        wr_be    = 2'b00;
        rd_valid = 1'b0;
        rd_addr  = 9'h000;

        tick();
        tick();
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        sweep("sweep1");

        rd_chk("rd_1ff", 9'h1FF, 16'h0000, 1'b0, 16'h0000, 1'b1);
        rd_chk("rd_000", 9'h000, 16'h0000, 1'b0, 16'h00A5, 1'b0);

        wr("wr_full", 9'h010, 16'hABCD, 2'b11, 1'b0, 1'b0);
        wr("wr_lo", 9'h010, 16'h0012, 2'b01, 1'b0, 1'b0);
        rd_chk("rd_ab12", 9'h010, 16'hAB12, 1'b0, 16'hAB12, 1'b0);
        wr("wr_be0", 9'h010, 16'hFFFF, 2'b00, 1'b0, 1'b0);
        wr("wr_hi", 9'h010, 16'h3400, 2'b10, 1'b0, 1'b0);
        rd_chk("rd_3412", 9'h010, 16'h3412, 1'b0, 16'h3412, 1'b0);

        wr("wr_1", 9'h001, 16'h1111, 2'b11, 1'b0, 1'b0);
        wr("wr_2", 9'h002, 16'h2222, 2'b11, 1'b0, 1'b0);
        wr("wr_3", 9'h003, 16'h3333, 2'b11, 1'b0, 1'b0);
        b2b_a_rv   = 5'b01110;
        b2b_b_rv   = 5'b00111;
        b2b_a_data = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h3333};
        b2b_b_data = '{16'h1111, 16'h2222, 16'h3333, 16'h3333, 16'h3333};
        for (int k = 0; k < 5; k++) begin
            rd_valid = (k < 3);
            rd_addr  = 9'(k + 1);
            tick();
            chk_eq($sformatf("b2b.a_rv%0d", k), a_rd_rvalid, {31'd0, b2b_a_rv[k]});
            chk_eq($sformatf("b2b.b_rv%0d", k), b_rd_rvalid, {31'd0, b2b_b_rv[k]});
            if (k >= 1) chk_eq($sformatf("b2b.a_d%0d", k), a_rd_rdata, {16'd0, b2b_a_data[k]});
            chk_eq($sformatf("b2b.b_d%0d", k), b_rd_rdata, {16'd0, b2b_b_data[k]});
        end
        rd_valid = 1'b0;

        wr("wr_020", 9'h020, 16'h0001, 2'b11, 1'b0, 1'b0);
        rdw("rdw_full", 16'h5555, 2'b11, 16'h5555, 16'h0001);
        rdw("rdw_lo", 16'h00AA, 2'b01, 16'h55AA, 16'h5555);
        rd_chk("rd_020", 9'h020, 16'h55AA, 1'b0, 16'h55AA, 1'b0);

        // Write landing while A's read of the same word is still in flight.
        rd_valid = 1'b1;
        rd_addr  = 9'h010;
        tick();
        rd_valid = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 9'h010;
        wr_data  = 16'h9999;
        wr_be    = 2'b11;
        tick();
        wr_valid = 1'b0;
        chk_eq("inflight.a", {a_rd_rvalid, a_rd_rdata}, {15'd0, 1'b1, 16'h3412});
        tick();
        rd_chk("rd_9999", 9'h010, 16'h9999, 1'b0, 16'h9999, 1'b0);

        wr("wr_12c", 9'h12C, 16'h7777, 2'b11, 1'b0, 1'b1);
        rd_chk("rd_12c", 9'h12C, 16'h7777, 1'b0, 16'h0000, 1'b1);
        rd_chk("rd_noalias", 9'h000, 16'h0000, 1'b0, 16'h00A5, 1'b0);
        rd_chk("rd_12b", 9'h12B, 16'h0000, 1'b0, 16'h00A5, 1'b0);

        // Reset with reads in flight: nothing may emerge, sweep restarts.
        rd_valid = 1'b1;
        rd_addr  = 9'h001;
        tick();
        rd_addr = 9'h002;
        @(negedge clk);
        rst_n    = 1'b0;
        rd_valid = 1'b0;
        #1;
        chk_outputs_zero("rst_mid");
        tick();
        tick();
        chk_outputs_zero("rst_hold");
        rst_n = 1'b1;
        sweep("sweep2");
        rd_chk("rd_cleared", 9'h001, 16'h0000, 1'b0, 16'h00A5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
